if_id_queue: RTL and testbench
==============================

// Module: if_id_queue
// PURPOSE
//  Parametrised IF->ID decoupling queue. Replaces the single-entry IF/ID pipeline register with a DEPTH-entry circular FIFO.
//  Each entry holds {inst, inst_addr, predict_jump_enable}. Fetch pushes and decode pops using valid/ready handshakes.
//  Adds occupancy reporting and a synchronous flush for branch redirects. Sits between the fetch unit and the decoder.
// PARAMETERS
//  INST_W   32            instruction width (bits)
//  ADDR_W   32            instruction address width (bits)
//  DEPTH    4             number of entries; power of two, >= 2
//  NOP      32'h00000013  instruction presented on inst_o when queue empty
// PORTS
//  clk                    in   1                 clock, rising edge
//  rst_n                  in   1                 asynchronous active-low reset
//  flush_i                in   1                 synchronous flush: discard all entries
//  push_valid_i           in   1                 fetch side: packet valid
//  push_ready_o           out  1                 fetch side: queue can accept
//  inst_i                 in   INST_W            fetched instruction
//  inst_addr_i            in   ADDR_W            fetched instruction address
//  predict_jump_enable_i  in   1                 predictor took a jump for this instruction
//  pop_valid_o            out  1                 decode side: head entry valid
//  pop_ready_i            in   1                 decode side: consumes head this cycle
//  inst_o                 out  INST_W            head instruction (NOP when empty)
//  inst_addr_o            out  ADDR_W            head address (0 when empty)
//  predict_jump_enable_o  out  1                 head predict bit (0 when empty)
//  count_o                out  $clog2(DEPTH)+1   current occupancy, 0..DEPTH
// BEHAVIOUR
//  - Reset (rst_n=0, async): wr_ptr=rd_ptr=0, count=0.
//    Outputs: push_ready_o=1, pop_valid_o=0, inst_o=NOP, inst_addr_o=0, predict_jump_enable_o=0, count_o=0.
//    Storage contents are don't-care. Reset mid-operation discards all entries immediately.
//  - push = push_valid_i & push_ready_o; pop = pop_valid_o & pop_ready_i. Both are evaluated at the rising edge.
//  - push_ready_o = (count != DEPTH). It is independent of pop_ready_i; there is no full-bypass.
//    When full, a push is refused even if a pop occurs in the same cycle.
//  - pop_valid_o = (count != 0).
//    inst_o/inst_addr_o/predict_jump_enable_o = mem[rd_ptr] when count != 0, otherwise NOP/0/0.
//  - Latency: a packet pushed at edge N is visible on the outputs after edge N; earliest pop is at edge N+1.
//    There is no empty-bypass.
//  - On push: mem[wr_ptr] <= packet, wr_ptr <= wr_ptr+1. On pop: rd_ptr <= rd_ptr+1.
//  - Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH (e.g. DEPTH-1 -> 0).
//  - count: +1 on push only, -1 on pop only, unchanged on both or neither. count never exceeds DEPTH and never goes below 0.
//  - Push and pop in the same cycle are legal whenever 0 < count < DEPTH; occupancy is unchanged.
//  - flush_i=1 at an edge: wr_ptr=rd_ptr=count=0. A same-cycle push or pop is ignored and no entry is written.
//    Outputs show the empty values after that edge.
//  - flush_i has priority over push and pop. Reset has priority over everything.
//  - Ordering: entries pop in exactly the order they were pushed; the fields of a packet are never split.
// TESTING
//  1. Reset, then idle -> count_o=0, pop_valid_o=0, inst_o=32'h00000013, inst_addr_o=0, push_ready_o=1.
//  2. Push 4 packets (addr 0x00,0x04,0x08,0x0C; inst 0xA0..0xA3; predict 0,1,0,0) with pop_ready_i=0.
//     -> count_o=4, push_ready_o=0.
//     A 5th push is refused: count stays 4 and a later pop shows no 5th entry.
//  3. From full, pop all four -> addresses 0x00,0x04,0x08,0x0C in order; predict bit 1 only on 0x04; then pop_valid_o=0.
//  4. Stream 10 packets with push and pop both asserted every cycle after the first push.
//     -> count_o holds 1, pointers wrap, and all 10 addresses are received in order with none lost.
//  5. With 3 entries queued, assert flush_i together with push_valid_i (addr 0x40).
//     -> next cycle count_o=0, pop_valid_o=0, inst_o=NOP; 0x40 is never popped.
//  6. Drop rst_n asynchronously mid-cycle with 2 entries queued.
//     -> outputs go to their reset values before the next clock edge.
//     After release, pushing 0x80 yields it as the head.

Source files
------------

// File: rtl/if_id_queue.sv
// IF->ID decoupling queue: DEPTH-entry circular FIFO of {inst, inst_addr, predict_jump_enable}
// with valid/ready on both sides, occupancy count and a synchronous flush for redirects.
module if_id_queue #(
  parameter int unsigned       INST_W = 32,
  parameter int unsigned       ADDR_W = 32,
  parameter int unsigned       DEPTH  = 4,
  parameter logic [INST_W-1:0] NOP    = INST_W'(32'h00000013)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_valid_i,
  output logic                     push_ready_o,
  input  logic [INST_W-1:0]        inst_i,
  input  logic [ADDR_W-1:0]        inst_addr_i,
  input  logic                     predict_jump_enable_i,
  output logic                     pop_valid_o,
  input  logic                     pop_ready_i,
  output logic [INST_W-1:0]        inst_o,
  output logic [ADDR_W-1:0]        inst_addr_o,
  output logic                     predict_jump_enable_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned EntW = INST_W + ADDR_W + 1;

  logic [EntW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;
  logic [EntW-1:0] head;

  assign push_ready_o = (count_q != CntW'(DEPTH));
  assign pop_valid_o  = (count_q != '0);
  assign push         = push_valid_i & push_ready_o;
  assign pop          = pop_valid_o & pop_ready_i;
  assign count_o      = count_q;

  // Pointers are exactly log2(DEPTH) bits, so increment wraps modulo DEPTH for free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push && !flush_i) begin
      mem_q[wr_ptr_q] <= {inst_i, inst_addr_i, predict_jump_enable_i};
    end
  end

  always_comb begin
    head                  = mem_q[rd_ptr_q];
    inst_o                = NOP;
    inst_addr_o           = '0;
    predict_jump_enable_o = 1'b0;
    if (pop_valid_o) begin
      {inst_o, inst_addr_o, predict_jump_enable_o} = head;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: driver queues expected packets, a negedge monitor
// checks every handshaken pop against the front of that queue.
module tb_if_id_queue;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        pj;
  } pkt_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        push_valid_i = 1'b0;
  logic        push_ready_o;
  logic [31:0] inst_i = '0;
  logic [31:0] inst_addr_i = '0;
  logic        predict_jump_enable_i = 1'b0;
  logic        pop_valid_o;
  logic        pop_ready_i = 1'b0;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        predict_jump_enable_o;
  logic [2:0]  count_o;

  int   checks = 0;
  int   failures = 0;
  pkt_t exp_q[$];
  pkt_t mon_p;

  if_id_queue #(
    .INST_W(32), .ADDR_W(32), .DEPTH(4), .NOP(32'h00000013)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .flush_i               (flush_i),
    .push_valid_i          (push_valid_i),
    .push_ready_o          (push_ready_o),
    .inst_i                (inst_i),
    .inst_addr_i           (inst_addr_i),
    .predict_jump_enable_i (predict_jump_enable_i),
    .pop_valid_o           (pop_valid_o),
    .pop_ready_i           (pop_ready_i),
    .inst_o                (inst_o),
    .inst_addr_o           (inst_addr_o),
    .predict_jump_enable_o (predict_jump_enable_o),
    .count_o               (count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic v, input logic [31:0] inst, input logic [31:0] addr,
                          input logic pj);
    push_valid_i          = v;
    inst_i                = inst;
    inst_addr_i           = addr;
    predict_jump_enable_i = pj;
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_count"}, 64'(count_o), 64'd0);
    check({tag, "_pop_valid"}, 64'(pop_valid_o), 64'd0);
    check({tag, "_inst"}, 64'(inst_o), 64'h13);
    check({tag, "_addr"}, 64'(inst_addr_o), 64'd0);
    check({tag, "_pj"}, 64'(predict_jump_enable_o), 64'd0);
    check({tag, "_push_ready"}, 64'(push_ready_o), 64'd1);
  endtask

  // A pop happens at the coming posedge whenever these are true mid-cycle.
  always @(negedge clk) begin
    if (rst_n && !flush_i && pop_valid_o && pop_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop actual_addr=%0h required=no_entry", inst_addr_o);
      end else begin
        mon_p = exp_q.pop_front();
        check("pop_inst", 64'(inst_o), 64'(mon_p.inst));
        check("pop_addr", 64'(inst_addr_o), 64'(mon_p.addr));
        check("pop_pj", 64'(predict_jump_enable_o), 64'(mon_p.pj));
      end
    end
  end

  initial begin
    // 1. reset and idle
    #12;
    rst_n = 1'b1;
    cycle();
    cycle();
    check_empty("reset");

    // 2. fill to full, then a refused 5th push
    for (int i = 0; i < 4; i++) begin
      set_push(1'b1, 32'hA0 + 32'(i), 32'(i * 4), (i == 1));
      exp_q.push_back('{inst: 32'hA0 + 32'(i), addr: 32'(i * 4), pj: (i == 1)});
      cycle();
    end
    set_push(1'b0, '0, '0, 1'b0);
    check("full_count", 64'(count_o), 64'd4);
    check("full_push_ready", 64'(push_ready_o), 64'd0);
    check("full_pop_valid", 64'(pop_valid_o), 64'd1);
    set_push(1'b1, 32'hA4, 32'h10, 1'b1);
    cycle();
    set_push(1'b0, '0, '0, 1'b0);
    check("refused_count", 64'(count_o), 64'd4);

    // 3. drain in order; a 5th pop attempt would hit an empty scoreboard
    pop_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    pop_ready_i = 1'b0;
    check_empty("drained");
    check("drain_sb_empty", 64'(exp_q.size()), 64'd0);

    // 4. streaming: push every cycle, pop from the second cycle on
    for (int i = 0; i < 10; i++) begin
      set_push(1'b1, 32'hB0 + 32'(i), 32'h100 + 32'(i * 4), i[0]);
      exp_q.push_back('{inst: 32'hB0 + 32'(i), addr: 32'h100 + 32'(i * 4), pj: i[0]});
      pop_ready_i = (i != 0);
      cycle();
      check("stream_count", 64'(count_o), 64'd1);
    end
    set_push(1'b0, '0, '0, 1'b0);
    cycle();
    pop_ready_i = 1'b0;
    check("stream_drained_count", 64'(count_o), 64'd0);
    check("stream_sb_empty", 64'(exp_q.size()), 64'd0);

    // 5. flush with a same-cycle push
    for (int i = 0; i < 3; i++) begin
      set_push(1'b1, 32'hD0 + 32'(i), 32'h20 + 32'(i * 4), 1'b0);
      cycle();
    end
    check("preflush_count", 64'(count_o), 64'd3);
    set_push(1'b1, 32'hD9, 32'h40, 1'b1);
    flush_i = 1'b1;
    cycle();
    flush_i = 1'b0;
    set_push(1'b0, '0, '0, 1'b0);
    check_empty("flush");
    pop_ready_i = 1'b1;
    cycle();
    cycle();
    pop_ready_i = 1'b0;

    // 6. asynchronous reset mid-cycle with two entries queued
    for (int i = 0; i < 2; i++) begin
      set_push(1'b1, 32'hE0 + 32'(i), 32'h60 + 32'(i * 4), 1'b1);
      cycle();
    end
    set_push(1'b0, '0, '0, 1'b0);
    check("prereset_count", 64'(count_o), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_empty("async_reset");
    cycle();
    rst_n = 1'b1;
    set_push(1'b1, 32'hC0, 32'h80, 1'b0);
    exp_q.push_back('{inst: 32'hC0, addr: 32'h80, pj: 1'b0});
    cycle();
    set_push(1'b0, '0, '0, 1'b0);
    check("post_reset_head", 64'(inst_addr_o), 64'h80);
    check("post_reset_count", 64'(count_o), 64'd1);
    pop_ready_i = 1'b1;
    cycle();
    cycle();
    pop_ready_i = 1'b0;
    check("final_sb_empty", 64'(exp_q.size()), 64'd0);
    check("final_count", 64'(count_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
